rf_wb_arbiter: RTL and testbench

Write-port controller for the 32x32 register file in the 5-stage core. Shares the file's single write port between the in-order pipeline writeback stage and a long-latency unit (multiply/divide) that returns results out of band. Pipeline writeback has priority, with a starvation guard. An optional scoreboard tracks registers that still wait for a long-latency result, so the hazard unit can stall dependent instructions.

---
 rtl/rf_wb_arbiter.sv | 153 +++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// Write-port arbiter for the 32x32 register file: pipeline writeback vs. long-latency unit,
// with a starvation guard. Define RF_WB_ARB_SCOREBOARD_EN to build the LU busy scoreboard.
module rf_wb_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wb_we_i,
  input  logic [4:0]  wb_rd_i,
  input  logic [31:0] wb_wd_i,
  input  logic        lu_valid_i,
  input  logic [4:0]  lu_rd_i,
  input  logic [31:0] lu_wd_i,
  output logic        lu_ready_o,
  output logic        wb_stall_o,
  input  logic        issue_i,
  input  logic [4:0]  issue_rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  output logic        rs1_busy_o,
  output logic        rs2_busy_o,
  output logic        rf_we_o,
  output logic [4:0]  rf_a3_o,
  output logic [31:0] rf_wd3_o
);

  localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);

  logic        wb_req_s;
  logic        lu_zero_s;
  logic        forced_s;
  logic        lu_hs_s;
  logic        lu_grant_s;
  logic        wb_grant_s;
  logic        lu_ready_s;
  logic        wb_stall_s;
  logic        rf_we_s;
  logic [4:0]  rf_a3_s;
  logic [31:0] rf_wd3_s;
  logic [3:0]  cnt_r;
  logic [3:0]  cnt_nxt_s;

  assign wb_req_s  = wb_we_i && (wb_rd_i != 5'd0);
  assign lu_zero_s = (lu_rd_i == 5'd0);
  assign forced_s  = (cnt_r >= LIMIT_C);
  assign lu_hs_s   = lu_valid_i && lu_ready_s;

  // Grant decision: WB wins unless the pending LU result has waited too long
  always_comb begin
    lu_ready_s = 1'b0;
    wb_stall_s = 1'b0;
    lu_grant_s = 1'b0;
    wb_grant_s = 1'b0;
    if (!wb_req_s) begin
      lu_ready_s = lu_valid_i;
      lu_grant_s = lu_valid_i;
    end else if (lu_valid_i && lu_zero_s) begin
      // x0 results need no port, so they never contend with WB
      lu_ready_s = 1'b1;
      wb_grant_s = 1'b1;
    end else if (forced_s && lu_valid_i) begin
      lu_ready_s = 1'b1;
      lu_grant_s = 1'b1;
      wb_stall_s = 1'b1;
    end else begin
      wb_grant_s = 1'b1;
    end
  end

  // Write-port mux; address and data are zeroed when no write happens
  always_comb begin
    rf_we_s  = 1'b0;
    rf_a3_s  = 5'd0;
    rf_wd3_s = 32'd0;
    if (lu_grant_s && !lu_zero_s) begin
      rf_we_s  = 1'b1;
      rf_a3_s  = lu_rd_i;
      rf_wd3_s = lu_wd_i;
    end else if (wb_grant_s) begin
      rf_we_s  = 1'b1;
      rf_a3_s  = wb_rd_i;
      rf_wd3_s = wb_wd_i;
    end else begin
      rf_we_s  = 1'b0;
    end
  end

  // Starvation counter next value
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (lu_hs_s) begin
      cnt_nxt_s = 4'd0;
    end else if (lu_valid_i && (cnt_r != 4'd15)) begin
      cnt_nxt_s = cnt_r + 4'd1;
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Starvation counter register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_r <= 4'd0;
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

`ifdef RF_WB_ARB_SCOREBOARD_EN
  logic [31:0] busy_r;
  logic [31:0] busy_nxt_s;

  // Scoreboard next value: clear on LU handshake, then set on issue so set wins
  always_comb begin
    busy_nxt_s = busy_r;
    if (lu_hs_s) begin
      busy_nxt_s[lu_rd_i] = 1'b0;
    end else begin
      busy_nxt_s = busy_r;
    end
    if (issue_i && (issue_rd_i != 5'd0)) begin
      busy_nxt_s[issue_rd_i] = 1'b1;
    end else begin
      busy_nxt_s[0] = 1'b0;
    end
    busy_nxt_s[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_r <= 32'd0;
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  assign rs1_busy_o = (rs1_i != 5'd0) ? busy_r[rs1_i] : 1'b0;
  assign rs2_busy_o = (rs2_i != 5'd0) ? busy_r[rs2_i] : 1'b0;
`else
  logic unused_sb_s;
  assign unused_sb_s = ^{issue_i, issue_rd_i, rs1_i, rs2_i};
  assign rs1_busy_o  = 1'b0;
  assign rs2_busy_o  = 1'b0;
`endif

  assign lu_ready_o = lu_ready_s;
  assign wb_stall_o = wb_stall_s;
  assign rf_we_o    = rf_we_s;
  assign rf_a3_o    = rf_a3_s;
  assign rf_wd3_o   = rf_wd3_s;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter (STARVE_LIMIT=4); scoreboard
// expectations follow RF_WB_ARB_SCOREBOARD_EN.
module tb_rf_wb_arbiter;

`ifdef RF_WB_ARB_SCOREBOARD_EN
  localparam logic SB_C = 1'b1;
`else
  localparam logic SB_C = 1'b0;
`endif

  logic        clk_s = 1'b0;
  logic        rst_s;
  logic        wb_we_s;
  logic [4:0]  wb_rd_s;
  logic [31:0] wb_wd_s;
  logic        lu_valid_s;
  logic [4:0]  lu_rd_s;
  logic [31:0] lu_wd_s;
  logic        lu_ready_s;
  logic        wb_stall_s;
  logic        issue_s;
  logic [4:0]  issue_rd_s;
  logic [4:0]  rs1_s;
  logic [4:0]  rs2_s;
  logic        rs1_busy_s;
  logic        rs2_busy_s;
  logic        rf_we_s;
  logic [4:0]  rf_a3_s;
  logic [31:0] rf_wd3_s;

  int pass_cnt  = 0;
  int total_cnt = 0;

  rf_wb_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk_i(clk_s), .rst_i(rst_s),
    .wb_we_i(wb_we_s), .wb_rd_i(wb_rd_s), .wb_wd_i(wb_wd_s),
    .lu_valid_i(lu_valid_s), .lu_rd_i(lu_rd_s), .lu_wd_i(lu_wd_s),
    .lu_ready_o(lu_ready_s), .wb_stall_o(wb_stall_s),
    .issue_i(issue_s), .issue_rd_i(issue_rd_s),
    .rs1_i(rs1_s), .rs2_i(rs2_s),
    .rs1_busy_o(rs1_busy_s), .rs2_busy_o(rs2_busy_s),
    .rf_we_o(rf_we_s), .rf_a3_o(rf_a3_s), .rf_wd3_o(rf_wd3_s)
  );

  always #5 clk_s = ~clk_s;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic set_in(input logic we, input logic [4:0] wrd, input logic [31:0] wwd,
                        input logic lv, input logic [4:0] lrd, input logic [31:0] lwd);
    wb_we_s = we; wb_rd_s = wrd; wb_wd_s = wwd;
    lu_valid_s = lv; lu_rd_s = lrd; lu_wd_s = lwd;
  endtask

  task automatic set_sb(input logic iss, input logic [4:0] ird, input logic [4:0] r1, input logic [4:0] r2);
    issue_s = iss; issue_rd_s = ird; rs1_s = r1; rs2_s = r2;
  endtask

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk_s);
    #1;
  endtask

  task automatic check_port(input string tag, input logic we, input logic [4:0] a3, input logic [31:0] wd,
                            input logic rdy, input logic stall);
    check_eq({tag, "_we"},    {31'd0, rf_we_s},    {31'd0, we});
    check_eq({tag, "_a3"},    {27'd0, rf_a3_s},    {27'd0, a3});
    check_eq({tag, "_wd"},    rf_wd3_s,            wd);
    check_eq({tag, "_ready"}, {31'd0, lu_ready_s}, {31'd0, rdy});
    check_eq({tag, "_stall"}, {31'd0, wb_stall_s}, {31'd0, stall});
  endtask

  initial begin
    rst_s = 1'b1;
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    set_sb(1'b0, 5'd0, 5'd0, 5'd0);
    repeat (2) @(posedge clk_s);
    #1 rst_s = 1'b0;

    // build up state, then reset asynchronously mid-cycle
    set_in(1'b1, 5'd3, 32'h0000_0033, 1'b1, 5'd9, 32'h0000_0099);
    set_sb(1'b1, 5'd10, 5'd10, 5'd0);
    tick();
    tick();
    set_sb(1'b0, 5'd0, 5'd10, 5'd0);
    check_eq("pre_rst_cnt", {28'd0, dut.cnt_r}, 32'd2);
    #3;
    rst_s = 1'b1;
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #1;
    check_eq("rst_cnt", {28'd0, dut.cnt_r}, 32'd0);
    check_port("rst", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    check_eq("rst_busy", {31'd0, rs1_busy_s}, 32'd0);
    tick();
    rst_s = 1'b0;

    // WB only
    set_in(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0);
    #1 check_port("wb_only", 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 1'b0);
    tick();

    // LU only
    set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h1234_5678);
    #1 check_port("lu_only", 1'b1, 5'd7, 32'h1234_5678, 1'b1, 1'b0);
    tick();
    check_eq("lu_only_cnt", {28'd0, dut.cnt_r}, 32'd0);

    // starvation: WB to x3 every cycle, LU holds rd=9
    set_in(1'b1, 5'd3, 32'h0000_0033, 1'b1, 5'd9, 32'h0000_0099);
    for (int i = 0; i < 4; i++) begin
      #1 check_port($sformatf("starve%0d", i), 1'b1, 5'd3, 32'h0000_0033, 1'b0, 1'b0);
      tick();
    end
    check_eq("starve_cnt4", {28'd0, dut.cnt_r}, 32'd4);
    #1 check_port("forced", 1'b1, 5'd9, 32'h0000_0099, 1'b1, 1'b1);
    tick();
    set_in(1'b1, 5'd3, 32'h0000_0033, 1'b0, 5'd0, 32'd0);
    #1 check_port("after_forced", 1'b1, 5'd3, 32'h0000_0033, 1'b0, 1'b0);
    check_eq("after_forced_cnt", {28'd0, dut.cnt_r}, 32'd0);
    tick();

    // WB to x0 never contends
    set_in(1'b1, 5'd0, 32'h0000_00AA, 1'b1, 5'd4, 32'h0000_0044);
    #1 check_port("wb_x0", 1'b1, 5'd4, 32'h0000_0044, 1'b1, 1'b0);
    tick();

    // LU to x0 accepted at once while WB writes
    set_in(1'b1, 5'd6, 32'h0000_0066, 1'b1, 5'd0, 32'h0000_0055);
    #1 check_port("lu_x0_wb", 1'b1, 5'd6, 32'h0000_0066, 1'b1, 1'b0);
    tick();

    // LU to x0 alone: no port write
    set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h0000_0055);
    #1 check_port("lu_x0", 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    tick();
    check_eq("lu_x0_cnt", {28'd0, dut.cnt_r}, 32'd0);

    // scoreboard set
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    set_sb(1'b1, 5'd10, 5'd10, 5'd0);
    #1 check_eq("sb_pre", {31'd0, rs1_busy_s}, 32'd0);
    tick();
    set_sb(1'b0, 5'd0, 5'd10, 5'd10);
    #1 check_eq("sb_set_rs1", {31'd0, rs1_busy_s}, {31'd0, SB_C});
    check_eq("sb_set_rs2", {31'd0, rs2_busy_s}, {31'd0, SB_C});

    // same-cycle handshake and re-issue: set wins, no bypass
    set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'h0000_1010);
    set_sb(1'b1, 5'd10, 5'd10, 5'd0);
    #1 check_eq("sb_both_now", {31'd0, rs1_busy_s}, {31'd0, SB_C});
    check_eq("sb_both_rdy", {31'd0, lu_ready_s}, 32'd1);
    tick();
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    set_sb(1'b0, 5'd0, 5'd10, 5'd0);
    #1 check_eq("sb_both_next", {31'd0, rs1_busy_s}, {31'd0, SB_C});

    // handshake alone clears next cycle
    set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'h0000_1010);
    #1 check_eq("sb_clr_now", {31'd0, rs1_busy_s}, {31'd0, SB_C});
    tick();
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #1 check_eq("sb_clr_next", {31'd0, rs1_busy_s}, 32'd0);

    // x0 is never busy
    set_sb(1'b1, 5'd0, 5'd0, 5'd0);
    tick();
    set_sb(1'b0, 5'd0, 5'd0, 5'd0);
    #1 check_eq("sb_x0_rs1", {31'd0, rs1_busy_s}, 32'd0);
    check_eq("sb_x0_rs2", {31'd0, rs2_busy_s}, 32'd0);
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
